// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller -- multi-cycle MIPS-subset control unit (Moore FSM).
//
// Sequences fetch, decode and execute of lw/sw, R-type ALU ops, addi/slti,
// beq, j, jal and jr.  Each state drives a fixed set of datapath enables and
// selects. Any output not named for a state stays 0.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset; also forces all outputs 0
//   opc[5:0]     in   IR opcode field inst[31:26]
//   func[5:0]    in   IR function field inst[5:0]
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite
//                out  datapath enables/selects
//   RegDst[1:0]  out  00 rt, 01 rd, 10 r31
//   RegData[1:0] out  00 ALUOut, 01 MDR, 10 PC
//   ALUSrcA      out  0 PC, 1 A
//   ALUSrcB[1:0] out  00 B, 01 4, 10 simm, 11 simm<<2
//   ALUctrl[2:0] out  010 add, 110 sub, 000 and, 001 or, 111 slt
//   PCSrc[1:0]   out  00 ALU, 01 ALUOut, 10 jump target, 11 A
//   illegal_op   out  sticky flag, set when ID sees an undecoded instruction
//
// Optional feature (macro MC_PERF_CNT_EN):
//   cycle_cnt[31:0] out  counts every non-reset edge
//   instr_cnt[31:0] out  counts completed instructions
// ---------------------------------------------------------------------------
module mc_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] RegData,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUctrl,
  output logic [1:0] PCSrc,
  output logic       illegal_op
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_MADDR, S_MRD, S_MWB, S_MWR, S_REX,
    S_RWB, S_IEX, S_IWB, S_BEQ, S_JMP, S_JAL, S_JR
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    RegData     = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUctrl     = 3'b000;
    PCSrc       = 2'b00;
    illegal_op  = illegal_q;

    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUctrl = ALU_ADD;
        state_d = S_ID;
      end
      S_ID: begin
        // Branch target PC + (simm<<2) is precomputed here for BEQ.
        ALUSrcB = 2'b11;
        ALUctrl = ALU_ADD;
        case (opc)
          OP_LW, OP_SW:    state_d = S_MADDR;
          OP_ADDI, OP_SLTI: state_d = S_IEX;
          OP_BEQ:          state_d = S_BEQ;
          OP_J:            state_d = S_JMP;
          OP_JAL:          state_d = S_JAL;
          OP_RTYPE: begin
            case (func)
              F_ADD, F_SUB, F_AND, F_OR, F_SLT: state_d = S_REX;
              F_JR:                              state_d = S_JR;
              default: begin
                state_d   = S_IF;
                illegal_d = 1'b1;
              end
            endcase
          end
          default: begin
            state_d   = S_IF;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUctrl = ALU_ADD;
        state_d = (opc == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_MWB;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        RegData  = 2'b01;
        state_d  = S_IF;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_IF;
      end
      S_REX: begin
        ALUSrcA = 1'b1;
        case (func)
          F_ADD:   ALUctrl = ALU_ADD;
          F_SUB:   ALUctrl = ALU_SUB;
          F_AND:   ALUctrl = ALU_AND;
          F_OR:    ALUctrl = ALU_OR;
          F_SLT:   ALUctrl = ALU_SLT;
          default: ALUctrl = 3'b000;
        endcase
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_IF;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUctrl = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_BEQ: begin
        // The datapath ANDs PCWriteCond with the ALU zero flag.
        PCWriteCond = 1'b1;
        ALUSrcA     = 1'b1;
        ALUctrl     = ALU_SUB;
        PCSrc       = 2'b01;
        state_d     = S_IF;
      end
      S_JMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        state_d = S_IF;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        RegData  = 2'b10;
        state_d  = S_IF;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b11;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset wins over everything so no write can leak out mid-instruction.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      RegData     = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUctrl     = 3'b000;
      PCSrc       = 2'b00;
      illegal_op  = 1'b0;
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;
  logic        instr_done;

  // Last state of every legal instruction; illegal ones are not counted.
  assign instr_done = (state_q == S_MWB) || (state_q == S_MWR) ||
                      (state_q == S_RWB) || (state_q == S_IWB) ||
                      (state_q == S_BEQ) || (state_q == S_JMP) ||
                      (state_q == S_JAL) || (state_q == S_JR);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  assign cycle_cnt = rst ? 32'd0 : cycle_cnt_q;
  assign instr_cnt = rst ? 32'd0 : instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller -- scoreboard bench for mc_controller.
// The driver issues one instruction at a time and pushes the expected
// per-cycle control vector, derived from the instruction's class, into a
// queue. A monitor pops one entry on every falling edge and compares.
// ---------------------------------------------------------------------------
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc, func;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, RegData, ALUSrcB, PCSrc;
  logic       ALUSrcA, illegal_op;
  logic [2:0] ALUctrl;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .RegData(RegData),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl),
    .PCSrc(PCSrc), .illegal_op(illegal_op)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] sig;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_cyc = 0;

  // Model state: sticky illegal flag and the two performance counters.
  logic        m_ill;
  logic [31:0] m_cyc, m_ins;

  // Instruction classes: 0 illegal, 1 lw, 2 sw, 3 R-alu, 4 jr, 5 addi,
  // 6 slti, 7 beq, 8 j, 9 jal.
  function automatic int kind_of(logic [5:0] o, logic [5:0] f);
    if (o == 6'b100011) return 1;
    if (o == 6'b101011) return 2;
    if (o == 6'b001000) return 5;
    if (o == 6'b001010) return 6;
    if (o == 6'b000100) return 7;
    if (o == 6'b000010) return 8;
    if (o == 6'b000011) return 9;
    if (o == 6'b000000) begin
      if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
          f == 6'b100101 || f == 6'b101010) return 3;
      if (f == 6'b001000) return 4;
    end
    return 0;
  endfunction

  function automatic int cycles_of(int k);
    case (k)
      0: return 2;
      1: return 5;
      2, 3, 5, 6: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_func(logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  // Packs {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,
  //        RegDst,RegData,ALUSrcA,ALUSrcB,ALUctrl,PCSrc,illegal_op}.
  function automatic logic [19:0] mk(logic pcw, logic pcwc, logic iord,
      logic mrd, logic mwr, logic irw, logic rw, logic [1:0] rd,
      logic [1:0] rdat, logic sa, logic [1:0] sb, logic [2:0] alu,
      logic [1:0] pcs);
    return {pcw, pcwc, iord, mrd, mwr, irw, rw, rd, rdat, sa, sb, alu, pcs, 1'b0};
  endfunction

  // Expected control vector for cycle idx of an instruction of class k.
  function automatic logic [19:0] model_vec(int k, int idx, logic [5:0] f, logic ill);
    logic [19:0] v;
    v = '0;
    if (idx == 0)      v = mk(1,0,0,1,0,1,0, 2'd0,2'd0, 0,2'd1,3'b010,2'd0); // fetch
    else if (idx == 1) v = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 0,2'd3,3'b010,2'd0); // decode
    else begin
      case (k)
        1: begin
          if (idx == 2)      v = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,3'b010,2'd0);
          else if (idx == 3) v = mk(0,0,1,1,0,0,0, 2'd0,2'd0, 0,2'd0,3'b000,2'd0);
          else               v = mk(0,0,0,0,0,0,1, 2'd0,2'd1, 0,2'd0,3'b000,2'd0);
        end
        2: begin
          if (idx == 2) v = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,3'b010,2'd0);
          else          v = mk(0,0,1,0,1,0,0, 2'd0,2'd0, 0,2'd0,3'b000,2'd0);
        end
        3: begin
          if (idx == 2) v = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,2'd0,alu_of_func(f),2'd0);
          else          v = mk(0,0,0,0,0,0,1, 2'd1,2'd0, 0,2'd0,3'b000,2'd0);
        end
        5, 6: begin
          if (idx == 2) v = mk(0,0,0,0,0,0,0, 2'd0,2'd0, 1,2'd2,
                               (k == 6) ? 3'b111 : 3'b010, 2'd0);
          else          v = mk(0,0,0,0,0,0,1, 2'd0,2'd0, 0,2'd0,3'b000,2'd0);
        end
        7: v = mk(0,1,0,0,0,0,0, 2'd0,2'd0, 1,2'd0,3'b110,2'd1);
        8: v = mk(1,0,0,0,0,0,0, 2'd0,2'd0, 0,2'd0,3'b000,2'd2);
        9: v = mk(1,0,0,0,0,0,1, 2'd2,2'd2, 0,2'd0,3'b000,2'd2);
        4: v = mk(1,0,0,0,0,0,0, 2'd0,2'd0, 0,2'd0,3'b000,2'd3);
        default: v = '0;
      endcase
    end
    v[0] = ill;
    return v;
  endfunction

  // All driver tasks are entered one time unit after a rising edge.
  task automatic do_reset(input int n);
    exp_t e;
    rst = 1'b1;
    e.sig = '0;
    e.cyc = '0;
    e.ins = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ill = 1'b0;
    m_cyc = '0;
    m_ins = '0;
    $display("reset cycles=%0d", n);
  endtask

  // abort_at > 0: reset is raised after that many cycles of the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
    exp_t e;
    int k, n, m;
    opc  = o;
    func = f;
    k = kind_of(o, f);
    n = cycles_of(k);
    m = (abort_at > 0 && abort_at < n) ? abort_at : n;
    for (int i = 0; i < m; i++) begin
      e.sig = model_vec(k, i, f, m_ill);
      e.cyc = m_cyc;
      e.ins = m_ins;
      exp_q.push_back(e);
      m_cyc = m_cyc + 32'd1;
      if (i == n - 1 && k != 0) m_ins = m_ins + 32'd1;
    end
    if (k == 0 && m == n) m_ill = 1'b1;
    $display("instr opc=%b func=%b class=%0d cycles=%0d%s", o, f, k, m,
             (m < n) ? " (reset mid-instruction)" : "");
    repeat (m) @(posedge clk);
    #1;
    if (m < n) do_reset(int'($urandom_range(1, 2)));
  endtask

  // Monitor: one scoreboard entry per falling edge while entries are pending.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
             RegDst, RegData, ALUSrcA, ALUSrcB, ALUctrl, PCSrc, illegal_op};
      n_cmp++;
      if (act !== e.sig) begin
        n_err++;
        $display("FAIL ctrl_vec @%0t: actual=%b required=%b", $time, act, e.sig);
      end
`ifdef MC_PERF_CNT_EN
      n_cmp++;
      if (cycle_cnt !== e.cyc || instr_cnt !== e.ins) begin
        n_err++;
        $display("FAIL perf_cnt @%0t: actual cyc=%0d ins=%0d required cyc=%0d ins=%0d",
                 $time, cycle_cnt, instr_cnt, e.cyc, e.ins);
      end
`endif
    end
  end

  initial begin
    logic [5:0] o, f;
    logic [5:0] rfuncs [5];
    int r;
    rfuncs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst = 1'b1;
    opc = 6'b100011;
    func = 6'b000000;
    m_ill = 1'b0;
    m_cyc = '0;
    m_ins = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed scenarios.
    run_instr(6'b100011, 6'b000000, 0);  // lw
    run_instr(6'b000000, 6'b101010, 0);  // slt
    run_instr(6'b000011, 6'b000000, 0);  // jal
    run_instr(6'b101011, 6'b000000, 0);  // sw
    run_instr(6'b000100, 6'b000000, 0);  // beq
    run_instr(6'b000010, 6'b000000, 0);  // j
    run_instr(6'b000000, 6'b001000, 0);  // jr
    run_instr(6'b001000, 6'b000000, 0);  // addi
    run_instr(6'b001010, 6'b000000, 0);  // slti
    run_instr(6'b111111, 6'b000000, 0);  // illegal
    run_instr(6'b000000, 6'b100010, 0);  // sub, flag must stay set
    run_instr(6'b000000, 6'b000111, 0);  // R-type with bad func
    run_instr(6'b100011, 6'b000000, 3);  // lw, reset while in MRD
    run_instr(6'b101011, 6'b000000, 0);  // sw after the abort

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 13));
      f = 6'($urandom);
      case (r)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2, 3: begin o = 6'b000000; f = rfuncs[$urandom_range(0, 4)]; end
        4: begin o = 6'b000000; f = 6'b001000; end
        5: o = 6'b001000;
        6: o = 6'b001010;
        7: o = 6'b000100;
        8: o = 6'b000010;
        9: o = 6'b000011;
        10: o = 6'b000000;
        default: o = 6'($urandom);
      endcase
      if ($urandom_range(0, 11) == 0)
        run_instr(o, f, int'($urandom_range(1, 4)));
      else
        run_instr(o, f, 0);
      if ($urandom_range(0, 39) == 0) do_reset(1);
    end

    // Bounded drain of any outstanding expectations.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: actual pending=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
